alu_iterative: RTL and testbench
================================

ALU_ITERATIVE -- requirements
Module: alu_iterative

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have parameter OPW, default 4, meaning opcode field width, taken from inst[15:12].
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inst  input  16  instruction word; opcode = inst[15:12].
REQ-006 SHALL have port start  input  1  request to begin the operation on the current inputs.
REQ-007 SHALL have ports register_A_in, register_B_in  input  WIDTH  operands A and B.
REQ-008 SHALL have ports Z_in, N_in, C_in  input  1  incoming zero/negative/carry flags.
REQ-009 SHALL have ports register_A_out, register_B_out  output  WIDTH  results (registered).
REQ-010 SHALL have ports Z_out, N_out, C_out  output  1  resulting flags (registered).
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  single-cycle pulse when results become valid.

Function
REQ-013 SHALL implement states IDLE, EXEC, DONE; IDLE->EXEC on start, EXEC->DONE when the iteration count expires, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL latch inst opcode, A, B and the flag inputs on the cycle start is sampled in IDLE; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start while busy or done is high (no queuing).
REQ-016 SHALL assert busy in EXEC only and done in DONE only; results and flags update on entry to DONE and hold until the next DONE.
REQ-017 Opcodes: 0100 ADD, 0101 SUB, 0110 AND, 0111 OR, 1000 XOR: 1 EXEC cycle, so done is high 2 cycles after the start cycle.
REQ-018 Opcodes: 1001 MUL (unsigned shift-add), 1010 DIV (unsigned restoring): WIDTH EXEC cycles, so done is high WIDTH+1 cycles after the start cycle.
REQ-019 ADD: A_out = (A+B) mod 2^WIDTH, C_out = carry out of bit WIDTH-1.
REQ-020 SUB: A_out = (A-B) mod 2^WIDTH, C_out = 1 iff A >= B unsigned (no borrow).
REQ-021 AND/OR/XOR: A_out = bitwise result, C_out = latched C_in.
REQ-022 MUL: {B_out, A_out} = full 2*WIDTH-bit product, C_out = 1 iff B_out != 0.
REQ-023 DIV: A_out = quotient, B_out = remainder, C_out = 0; divisor 0 SHALL give A_out = all ones, B_out = A, C_out = 1.
REQ-024 For non-MUL/DIV arithmetic and logic ops, B_out SHALL equal latched B.
REQ-025 Z_out = (A_out == 0); N_out = A_out[WIDTH-1] for every defined opcode.
REQ-026 Any other opcode SHALL complete in 1 EXEC cycle with A_out = A, B_out = B and flags = latched flag inputs.
REQ-027 The EXEC iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap during an operation.

Reset
REQ-028 rst high at a clock edge SHALL force state IDLE, busy = 0, done = 0, register_A_out = 0, register_B_out = 0, Z_out = N_out = C_out = 0.
REQ-029 rst SHALL abort an operation in EXEC or DONE with no done pulse; rst takes priority over start in the same cycle.
REQ-030 First start SHALL be accepted on the first cycle after rst deasserts.

Verification
REQ-031 ADD 1+1 (WIDTH=16): start with inst=0x4000 -> done at +2 cycles, A_out=0x0002, B_out=0x0001, Z/N/C=0/0/0.
REQ-032 SUB 1-1: inst=0x5000 -> A_out=0x0000, Z/N/C=1/0/1; SUB 0-1 -> A_out=0xFFFF, Z/N/C=0/1/0.
REQ-033 MUL 0xFFFF*0xFFFF: inst=0x9000 -> busy for 16 cycles, done at +17, B_out=0xFFFE, A_out=0x0001, C_out=1.
REQ-034 DIV 100/7 -> A_out=14, B_out=2; DIV 5/0 -> A_out=0xFFFF, B_out=5, C_out=1.
REQ-035 Start pulsed repeatedly during MUL plus operand changes -> ignored, result unchanged; rst asserted mid-MUL -> outputs 0, no done, next ADD correct.
REQ-036 ADD 0xFFFF+1 -> A_out=0, Z/C=1/1; repeat all scenarios with WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - iterative ALU with single-cycle logic ops and multi-cycle MUL/DIV
module alu_iterative #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      inst,
   input  logic             start,
   input  logic [WIDTH-1:0] register_A_in,
   input  logic [WIDTH-1:0] register_B_in,
   input  logic             Z_in,
   input  logic             N_in,
   input  logic             C_in,
   output logic [WIDTH-1:0] register_A_out,
   output logic [WIDTH-1:0] register_B_out,
   output logic             Z_out,
   output logic             N_out,
   output logic             C_out,
   output logic             busy,
   output logic             done
);

   // Counter only ever holds 1..WIDTH, so this width is enough and it never wraps.
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0100);
   localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0101);
   localparam logic [OPW-1:0] OP_AND = OPW'(4'b0110);
   localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0111);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4'b1000);
   localparam logic [OPW-1:0] OP_MUL = OPW'(4'b1001);
   localparam logic [OPW-1:0] OP_DIV = OPW'(4'b1010);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [OPW-1:0]       op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic                 z_q;
   logic                 n_q;
   logic                 c_q;
   // Shared MUL/DIV working register: upper half is accumulator/remainder,
   // lower half is multiplier/dividend being shifted out.
   logic [2*WIDTH-1:0]   work_q;
   logic [CW-1:0]        cnt_q;

   logic [OPW-1:0]       op_in;
   logic                 iter_in;

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   step_next;

   logic [WIDTH:0]       add_sum;
   logic [WIDTH-1:0]     res_a;
   logic [WIDTH-1:0]     res_b;
   logic                 res_z;
   logic                 res_n;
   logic                 res_c;
   logic                 res_defined;

   logic                 unused_bits;

   assign op_in   = inst[15 -: OPW];
   assign iter_in = (op_in == OP_MUL) || (op_in == OP_DIV);

   // Only the opcode field of inst matters; the top of the DIV subtraction
   // result is always zero when it is selected.
   assign unused_bits = ^{inst[15-OPW:0], div_shift[WIDTH], div_diff[WIDTH]};

   // One shift-add (MUL) or restoring shift-subtract (DIV) step on the working register.
   always_comb begin
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_diff  = div_shift - {1'b0, b_q};
      step_next = work_q;
      if (op_q == OP_MUL) begin
         step_next = {mul_sum, work_q[WIDTH-1:1]};
      end else if (op_q == OP_DIV) begin
         step_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      work_q[WIDTH-2:0], div_ge};
      end
   end

   // Final result and flags, valid in the last EXEC cycle (MUL/DIV use the final step).
   always_comb begin
      add_sum     = {1'b0, a_q} + {1'b0, b_q};
      res_a       = a_q;
      res_b       = b_q;
      res_c       = c_q;
      res_defined = 1'b1;
      case (op_q)
         OP_ADD: begin
            res_a = add_sum[WIDTH-1:0];
            res_c = add_sum[WIDTH];
         end
         OP_SUB: begin
            res_a = a_q - b_q;
            res_c = (a_q >= b_q);
         end
         OP_AND: res_a = a_q & b_q;
         OP_OR:  res_a = a_q | b_q;
         OP_XOR: res_a = a_q ^ b_q;
         OP_MUL: begin
            res_a = step_next[WIDTH-1:0];
            res_b = step_next[2*WIDTH-1:WIDTH];
            res_c = |step_next[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            if (b_q == '0) begin
               // Divide by zero: saturated quotient, dividend as remainder, C flags the error.
               res_a = '1;
               res_b = a_q;
               res_c = 1'b1;
            end else begin
               res_a = step_next[WIDTH-1:0];
               res_b = step_next[2*WIDTH-1:WIDTH];
               res_c = 1'b0;
            end
         end
         default: res_defined = 1'b0;
      endcase
      if (res_defined) begin
         res_z = (res_a == '0);
         res_n = res_a[WIDTH-1];
      end else begin
         res_z = z_q;
         res_n = n_q;
      end
   end

   // Control FSM with registered busy/done and result registers updated on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         register_A_out <= '0;
         register_B_out <= '0;
         Z_out          <= 1'b0;
         N_out          <= 1'b0;
         C_out          <= 1'b0;
         op_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         z_q            <= 1'b0;
         n_q            <= 1'b0;
         c_q            <= 1'b0;
         work_q         <= '0;
         cnt_q          <= '0;
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  op_q   <= op_in;
                  a_q    <= register_A_in;
                  b_q    <= register_B_in;
                  z_q    <= Z_in;
                  n_q    <= N_in;
                  c_q    <= C_in;
                  work_q <= {{WIDTH{1'b0}}, register_A_in};
                  cnt_q  <= iter_in ? CW'(WIDTH) : CW'(1);
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               work_q <= step_next;
               if (cnt_q == CW'(1)) begin
                  register_A_out <= res_a;
                  register_B_out <= res_b;
                  Z_out          <= res_z;
                  N_out          <= res_n;
                  C_out          <= res_c;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  state          <= DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - randomized self-checking bench running WIDTH 8, 16 and 32 side by side
module tb_alu_iterative;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] inst = '0;
   logic        start = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        z_in = 1'b0;
   logic        n_in = 1'b0;
   logic        c_in = 1'b0;

   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [31:0] a32, b32;
   logic        z8, n8, c8, busy8, done8;
   logic        z16, n16, c16, busy16, done16;
   logic        z32, n32, c32, busy32, done32;

   int checks = 0;
   int errors = 0;

   logic [31:0] got_a [3];
   logic [31:0] got_b [3];
   logic [2:0]  got_f [3];
   logic        got_busy [3];
   logic        got_done [3];

   logic [31:0] last_a [3];
   logic [31:0] last_b [3];
   logic [2:0]  last_f [3];

   always #5 clk = ~clk;

   alu_iterative #(.WIDTH(8), .OPW(4)) u8 (
      .clk(clk), .rst(rst), .inst(inst), .start(start),
      .register_A_in(a_in[7:0]), .register_B_in(b_in[7:0]),
      .Z_in(z_in), .N_in(n_in), .C_in(c_in),
      .register_A_out(a8), .register_B_out(b8),
      .Z_out(z8), .N_out(n8), .C_out(c8), .busy(busy8), .done(done8));

   alu_iterative #(.WIDTH(16), .OPW(4)) u16 (
      .clk(clk), .rst(rst), .inst(inst), .start(start),
      .register_A_in(a_in[15:0]), .register_B_in(b_in[15:0]),
      .Z_in(z_in), .N_in(n_in), .C_in(c_in),
      .register_A_out(a16), .register_B_out(b16),
      .Z_out(z16), .N_out(n16), .C_out(c16), .busy(busy16), .done(done16));

   alu_iterative #(.WIDTH(32), .OPW(4)) u32 (
      .clk(clk), .rst(rst), .inst(inst), .start(start),
      .register_A_in(a_in), .register_B_in(b_in),
      .Z_in(z_in), .N_in(n_in), .C_in(c_in),
      .register_A_out(a32), .register_B_out(b32),
      .Z_out(z32), .N_out(n32), .C_out(c32), .busy(busy32), .done(done32));

   assign got_a[0] = {24'd0, a8};
   assign got_a[1] = {16'd0, a16};
   assign got_a[2] = a32;
   assign got_b[0] = {24'd0, b8};
   assign got_b[1] = {16'd0, b16};
   assign got_b[2] = b32;
   assign got_f[0] = {z8, n8, c8};
   assign got_f[1] = {z16, n16, c16};
   assign got_f[2] = {z32, n32, c32};
   assign got_busy[0] = busy8;
   assign got_busy[1] = busy16;
   assign got_busy[2] = busy32;
   assign got_done[0] = done8;
   assign got_done[1] = done16;
   assign got_done[2] = done32;

   function automatic int wid(input int i);
      return (i == 0) ? 8 : ((i == 1) ? 16 : 32);
   endfunction

   // Reference: plain arithmetic on 64-bit integers, masked to the datapath width.
   function automatic void model(input int w, input logic [3:0] op,
                                 input logic [31:0] ai, input logic [31:0] bi,
                                 input logic zi, input logic ni, input logic ci,
                                 output logic [31:0] ra, output logic [31:0] rb,
                                 output logic [2:0] rf, output int lat);
      longint unsigned mask, a, b, r, rbl;
      logic c;
      logic defined;
      mask    = (64'd1 << w) - 64'd1;
      a       = {32'd0, ai} & mask;
      b       = {32'd0, bi} & mask;
      r       = a;
      rbl     = b;
      c       = ci;
      defined = 1'b1;
      lat     = 1;
      case (op)
         4'h4: begin r = a + b; c = ((r >> w) & 64'd1) != 0; r = r & mask; end
         4'h5: begin r = (a - b) & mask; c = (a >= b); end
         4'h6: r = a & b;
         4'h7: r = a | b;
         4'h8: r = a ^ b;
         4'h9: begin
            r   = (a * b) & mask;
            rbl = ((a * b) >> w) & mask;
            c   = (rbl != 0);
            lat = w;
         end
         4'hA: begin
            lat = w;
            if (b == 0) begin r = mask; rbl = a; c = 1'b1; end
            else begin r = a / b; rbl = a % b; c = 1'b0; end
         end
         default: defined = 1'b0;
      endcase
      ra = 32'(r);
      rb = 32'(rbl);
      if (defined) rf = {(r == 0), (((r >> (w - 1)) & 64'd1) != 0), c};
      else         rf = {zi, ni, ci};
   endfunction

   // Starts one operation on all three widths at the current negedge, scrambles
   // inputs (and optionally pulses start) while running, then checks each DUT.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic z, input logic n, input logic c, input bit spam);
      int          done_k [3];
      int          done_n [3];
      int          busy_n [3];
      int          lat [3];
      logic [31:0] ea [3];
      logic [31:0] eb [3];
      logic [2:0]  ef [3];
      int          min_done;
      for (int i = 0; i < 3; i++) begin
         model(wid(i), op, a, b, z, n, c, ea[i], eb[i], ef[i], lat[i]);
         done_k[i] = 0;
         done_n[i] = 0;
         busy_n[i] = 0;
      end
      min_done = lat[0] + 1;
      inst  = {op, 12'($urandom)};
      a_in  = a;
      b_in  = b;
      z_in  = z;
      n_in  = n;
      c_in  = c;
      start = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (got_busy[i]) busy_n[i]++;
            if (got_done[i]) begin
               done_n[i]++;
               if (done_k[i] == 0) begin
                  done_k[i] = k;
                  last_a[i] = got_a[i];
                  last_b[i] = got_b[i];
                  last_f[i] = got_f[i];
               end
            end
         end
         a_in  = $urandom;
         b_in  = $urandom;
         inst  = 16'($urandom);
         z_in  = 1'($urandom);
         n_in  = 1'($urandom);
         c_in  = 1'($urandom);
         start = (spam && k <= min_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (done_k[i] !== lat[i] + 1) begin
            errors++;
            $display("FAIL latency w=%0d op=%h got done at cycle %0d expected %0d", wid(i), op, done_k[i], lat[i] + 1);
         end
         checks++;
         if (done_n[i] !== 1 || busy_n[i] !== lat[i]) begin
            errors++;
            $display("FAIL pulses w=%0d op=%h got done_cycles=%0d busy_cycles=%0d expected 1/%0d", wid(i), op, done_n[i], busy_n[i], lat[i]);
         end
         checks++;
         if (last_a[i] !== ea[i] || last_b[i] !== eb[i]) begin
            errors++;
            $display("FAIL result w=%0d op=%h a=%h b=%h got A=%h B=%h expected A=%h B=%h", wid(i), op, a, b, last_a[i], last_b[i], ea[i], eb[i]);
         end
         checks++;
         if (last_f[i] !== ef[i]) begin
            errors++;
            $display("FAIL flags w=%0d op=%h a=%h b=%h got ZNC=%b expected %b", wid(i), op, a, b, last_f[i], ef[i]);
         end
      end
   endtask

   // Applies one reset cycle (with start high to show reset wins) and checks cleared outputs.
   task automatic do_reset(input string tag);
      rst   = 1'b1;
      start = 1'b1;
      inst  = 16'h4000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_a[i] !== 32'd0 || got_b[i] !== 32'd0 || got_f[i] !== 3'b000 ||
             got_busy[i] !== 1'b0 || got_done[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s w=%0d got A=%h B=%h ZNC=%b busy=%b done=%b expected all zero",
                     tag, wid(i), got_a[i], got_b[i], got_f[i], got_busy[i], got_done[i]);
         end
      end
      rst   = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      do_reset("reset_state");
   endtask

   task automatic check16(input string tag, input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] ef);
      checks++;
      if (last_a[1] !== ea || last_b[1] !== eb || last_f[1] !== ef) begin
         errors++;
         $display("FAIL %s got A=%h B=%h ZNC=%b expected A=%h B=%h ZNC=%b", tag, last_a[1], last_b[1], last_f[1], ea, eb, ef);
      end
   endtask

   task automatic test_directed();
      run_op(4'h4, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("add_1_1", 32'h0002, 32'h0001, 3'b000);
      run_op(4'h5, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("sub_1_1", 32'h0000, 32'h0001, 3'b101);
      run_op(4'h5, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("sub_0_1", 32'hFFFF, 32'h0001, 3'b010);
      run_op(4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("mul_max", 32'h0001, 32'hFFFE, 3'b001);
      run_op(4'hA, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      check16("div_100_7", 32'd14, 32'd2, 3'b000);
      run_op(4'hA, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("div_by_zero", 32'hFFFF, 32'd5, 3'b011);
      run_op(4'h4, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("add_wrap", 32'h0000, 32'h0001, 3'b101);
      run_op(4'hF, 32'h1234ABCD, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, 1'b0);
      check16("undefined_op", 32'hABCD, 32'h0F0F, 3'b101);
   endtask

   task automatic test_start_ignored();
      run_op(4'h9, 32'hDEADBEEF, 32'h12345679, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op(4'hA, 32'hFEDCBA98, 32'h00000013, 1'b1, 1'b1, 1'b1, 1'b1);
      run_op(4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_abort();
      inst  = 16'h9000;
      a_in  = 32'hFFFFFFFF;
      b_in  = 32'hFFFFFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      do_reset("abort_clear");
      begin
         int seen [3];
         for (int i = 0; i < 3; i++) seen[i] = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (got_done[i] || got_busy[i]) seen[i]++;
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen[i] !== 0) begin
               errors++;
               $display("FAIL abort_no_done w=%0d got %0d busy/done cycles expected 0", wid(i), seen[i]);
            end
         end
      end
      do_reset("reset_again");
      run_op(4'h4, 32'h00000005, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
      check16("add_after_reset", 32'h0008, 32'h0003, 3'b000);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(4, 10));
         run_op(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      run_op(4'h7, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(4'h8, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1, 1'b0);
      run_op(4'h9, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
      run_op(4'hA, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
